clock_meter: RTL and testbench
==============================

CLOCK_METER -- requirements
Module: clock_meter

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000000, giving the measurement window length in reference-clock cycles (1 s at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the edge-counter width.
REQ-003 The block SHALL have parameter FAST_MIN, default 1000000, giving the edge count at or above which a window is classed fast.
REQ-004 The block SHALL have port cm_clock50_i, input, 1 bit: the single 50 MHz reference clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port cm_rstn_i, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port cm_measClk_i, input, 1 bit: the clock under measurement (e.g. generated dev clock), asynchronous to cm_clock50_i.
REQ-007 The block SHALL have port cm_enable_i, input, 1 bit: high runs back-to-back measurement windows.
REQ-008 The block SHALL have port cm_ack_i, input, 1 bit: consumer acknowledge of the current result.
REQ-009 The block SHALL have port cm_count_o, output, CNT_W bits: rising edges counted in the last completed window.
REQ-010 The block SHALL have port cm_mode_o, output, 2 bits: class of the last result (00 stopped, 01 slow, 10 fast, 11 saturated).
REQ-011 The block SHALL have port cm_valid_o, output, 1 bit: an unacknowledged result is held.
REQ-012 The block SHALL have port cm_overrun_o, output, 1 bit: sticky flag, set when an unacknowledged result was overwritten.

Function
REQ-013 cm_measClk_i SHALL pass a 2-flop synchronizer; a third flop SHALL supply edge detect, with edge = sync2 & ~sync3.
REQ-014 A cm_measClk_i rising edge SHALL raise the edge strobe 2-3 reference cycles later, for exactly one cycle.
REQ-015 Correct counting SHALL be guaranteed for measured frequencies up to 1/4 of the reference; faster input is undefined.
REQ-016 The FSM SHALL use states IDLE, ARM, COUNT and PUBLISH.
REQ-017 In IDLE, the FSM SHALL move to ARM when cm_enable_i=1.
REQ-018 ARM SHALL last one cycle, clear the gate and edge counters, and go to COUNT.
REQ-019 COUNT SHALL increment the gate counter every cycle.
REQ-020 COUNT SHALL increment the edge counter on each strobe, saturating at 2^CNT_W-1.
REQ-021 When the gate counter = GATE_CYCLES-1, the FSM SHALL go to PUBLISH; a strobe in that final cycle is counted, so the window is exactly GATE_CYCLES cycles.
REQ-022 PUBLISH SHALL last one cycle, load cm_count_o and cm_mode_o, and set cm_valid_o.
REQ-023 From PUBLISH, the FSM SHALL go to ARM if cm_enable_i=1, else to IDLE.
REQ-024 Mode SHALL be 11 if count = 2^CNT_W-1, else 10 if count >= FAST_MIN, else 01 if count > 0, else 00.
REQ-025 cm_ack_i=1 with cm_valid_o=1 SHALL clear cm_valid_o and cm_overrun_o on the next edge; cm_ack_i while cm_valid_o=0 SHALL be ignored.
REQ-026 If PUBLISH occurs with cm_valid_o=1 and no ack that cycle, the block SHALL overwrite the result and set cm_overrun_o.
REQ-027 If PUBLISH and ack coincide, cm_valid_o SHALL stay 1, the new result SHALL load, and cm_overrun_o SHALL be unchanged by that event.
REQ-028 cm_enable_i=0 in ARM or COUNT SHALL abort to IDLE on the next edge, with no publish and all outputs held.
REQ-029 cm_count_o and cm_mode_o SHALL change only in PUBLISH.

Reset
REQ-030 cm_rstn_i low SHALL immediately force state IDLE, clear all counters and synchronizer flops, and drive cm_count_o=0, cm_mode_o=00, cm_valid_o=0 and cm_overrun_o=0, including mid-window.
REQ-031 Reset deassertion SHALL be synchronized externally; the block needs no minimum low time beyond one reference cycle.

Structure
REQ-032 Package clock_meter_pkg SHALL hold the FSM state enum, the mode enum (STOPPED, SLOW, FAST, SAT) and the default parameter constants.
REQ-033 The synchronizer and edge detect SHALL be one sub-module, sync_edge_detect (async in, 1-cycle strobe out, active-low async reset).

Verification (GATE_CYCLES=120, FAST_MIN=5, CNT_W=24)
REQ-034 The bench SHALL drive cm_measClk_i toggling every 6 reference cycles with enable=1 -> PUBLISH with cm_count_o=10 (+/-1 by phase), mode=10, cm_valid_o=1.
REQ-035 The bench SHALL drive cm_measClk_i toggling every 30 cycles -> cm_count_o=2, mode=01; holding it constant -> cm_count_o=0, mode=00.
REQ-036 The bench SHALL leave two windows unacknowledged -> second PUBLISH sets cm_overrun_o=1 and shows the new count; ack -> cm_valid_o=0 and cm_overrun_o=0 next cycle.
REQ-037 The bench SHALL assert ack in the exact PUBLISH cycle -> cm_valid_o stays 1, the new count loads, and cm_overrun_o stays 0.
REQ-038 The bench SHALL drop enable at gate count 60 -> IDLE next cycle, with no PUBLISH and outputs unchanged; re-enable -> a full 120-cycle window starting from ARM.
REQ-039 The bench SHALL pulse cm_rstn_i low mid-COUNT, asynchronous to the clock -> all outputs 0 immediately; after release with enable=1 -> first PUBLISH 1+120+1 cycles later.

Source files
------------

// File: rtl/clock_meter_pkg.sv
// clock_meter_pkg: FSM state and mode enums plus default parameter constants for clock_meter
package clock_meter_pkg;
  typedef enum logic [1:0] {IDLE, ARM, COUNT, PUBLISH} state_e;
  typedef enum logic [1:0] {STOPPED = 2'b00, SLOW = 2'b01, FAST = 2'b10, SAT = 2'b11} mode_e;
  localparam int unsigned GATE_CYCLES_DEF = 50000000;
  localparam int unsigned CNT_W_DEF = 24;
  localparam int unsigned FAST_MIN_DEF = 1000000;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: 2-flop synchronizer + edge flop; clk_i/rst_ni in, async_i in, edge_o one-cycle rising-edge strobe out
module sync_edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);
  logic [2:0] sync_q, sync_d;
  assign sync_d = {sync_q[1:0], async_i};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) sync_q <= '0;
    else sync_q <= sync_d;
  assign edge_o = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/clock_meter.sv
// clock_meter: counts cm_measClk_i rising edges over GATE_CYCLES reference cycles; ports clock/reset, measClk/enable/ack in, count/mode/valid/overrun out
module clock_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned FAST_MIN = FAST_MIN_DEF
) (
  input  logic             cm_clock50_i,
  input  logic             cm_rstn_i,
  input  logic             cm_measClk_i,
  input  logic             cm_enable_i,
  input  logic             cm_ack_i,
  output logic [CNT_W-1:0] cm_count_o,
  output logic [1:0]       cm_mode_o,
  output logic             cm_valid_o,
  output logic             cm_overrun_o
);
  localparam int GW = ($clog2(GATE_CYCLES) < 1) ? 1 : $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] FAST_THR = CNT_W'(FAST_MIN);
  state_e state_q, state_d;
  mode_e mode_q, mode_d, mode_nx;
  logic [GW-1:0] gate_q, gate_d;
  logic [CNT_W-1:0] edges_q, edges_d, count_q, count_d;
  logic valid_q, valid_d, ovr_q, ovr_d, strobe;
  sync_edge_detect u_sync (
    .clk_i  (cm_clock50_i),
    .rst_ni (cm_rstn_i),
    .async_i(cm_measClk_i),
    .edge_o (strobe)
  );
  always_comb
    mode_nx = (edges_q == CNT_MAX) ? SAT : (edges_q >= FAST_THR) ? FAST : (edges_q != '0) ? SLOW : STOPPED;
  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    edges_d = edges_q;
    count_d = count_q;
    mode_d  = mode_q;
    valid_d = valid_q & ~cm_ack_i;
    ovr_d   = (valid_q & cm_ack_i) ? 1'b0 : ovr_q;
    case (state_q)
      IDLE: state_d = cm_enable_i ? ARM : IDLE;
      ARM: begin
        gate_d  = '0;
        edges_d = '0;
        state_d = cm_enable_i ? COUNT : IDLE;
      end
      COUNT: begin
        gate_d  = gate_q + GW'(1);
        edges_d = (strobe && edges_q != CNT_MAX) ? edges_q + CNT_W'(1) : edges_q;
        state_d = !cm_enable_i ? IDLE : (gate_q == GATE_LAST) ? PUBLISH : COUNT;
      end
      PUBLISH: begin
        count_d = edges_q;
        mode_d  = mode_nx;
        valid_d = 1'b1;
        // an ack landing in the publish cycle consumes the old result, so no overrun
        ovr_d   = (valid_q & ~cm_ack_i) ? 1'b1 : ovr_q;
        state_d = cm_enable_i ? ARM : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge cm_clock50_i or negedge cm_rstn_i)
    if (!cm_rstn_i) begin
      state_q <= IDLE;
      gate_q  <= '0;
      edges_q <= '0;
      count_q <= '0;
      mode_q  <= STOPPED;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      edges_q <= edges_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  assign cm_count_o   = count_q;
  assign cm_mode_o    = mode_q;
  assign cm_valid_o   = valid_q;
  assign cm_overrun_o = ovr_q;
endmodule

// File: tb/tb_clock_meter.sv
// tb_clock_meter: directed self-checking bench for clock_meter with a 120-cycle window
module tb_clock_meter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic meas = 1'b0;
  logic enable = 1'b0;
  logic ack = 1'b0;
  logic [23:0] count;
  logic [1:0] mode;
  logic valid, ovr;
  int half = 0;
  int mcnt = 0;
  int n_cmp = 0;
  int n_err = 0;
  int halves [2] = '{12, 15};
  int exp_cnt [2] = '{5, 4};
  int exp_mode [2] = '{2, 1};
  clock_meter #(.GATE_CYCLES(120), .CNT_W(24), .FAST_MIN(5)) dut (
    .cm_clock50_i(clk),
    .cm_rstn_i   (rst_n),
    .cm_measClk_i(meas),
    .cm_enable_i (enable),
    .cm_ack_i    (ack),
    .cm_count_o  (count),
    .cm_mode_o   (mode),
    .cm_valid_o  (valid),
    .cm_overrun_o(ovr)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (half == 0) begin
      meas = 1'b0;
      mcnt = 0;
    end else begin
      mcnt = mcnt + 1;
      if (mcnt >= half) begin
        mcnt = 0;
        meas = ~meas;
      end
    end
  end
  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    #2 rst_n = 1'b0;
    ticks(3);
    check("rst_count", 32'(count), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_ovr", 32'(ovr), 0);
    #2 rst_n = 1'b1;
    half = 30;
    ticks(40);
    enable = 1'b1;
    ticks(122);
    check("slow_pre_valid", 32'(valid), 0);
    ticks(1);
    enable = 1'b0;
    check("slow_valid", 32'(valid), 1);
    check("slow_count", 32'(count), 2);
    check("slow_mode", 32'(mode), 1);
    check("slow_ovr", 32'(ovr), 0);
    half = 6;
    ticks(40);
    enable = 1'b1;
    ticks(122);
    check("fast_hold_count", 32'(count), 2);
    ack = 1'b1;
    ticks(1);
    ack = 1'b0;
    enable = 1'b0;
    check("pubAck_valid", 32'(valid), 1);
    check("pubAck_count", 32'(count), 10);
    check("pubAck_mode", 32'(mode), 2);
    check("pubAck_ovr", 32'(ovr), 0);
    half = 0;
    ticks(40);
    enable = 1'b1;
    ticks(123);
    enable = 1'b0;
    check("stop_count", 32'(count), 0);
    check("stop_mode", 32'(mode), 0);
    check("ovr_valid", 32'(valid), 1);
    check("ovr_set", 32'(ovr), 1);
    ack = 1'b1;
    ticks(1);
    ack = 1'b0;
    check("ack_valid", 32'(valid), 0);
    check("ack_ovr", 32'(ovr), 0);
    for (int i = 0; i < 2; i++) begin
      half = halves[i];
      ticks(40);
      enable = 1'b1;
      ticks(123);
      enable = 1'b0;
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(exp_cnt[i]));
      check($sformatf("tbl%0d_mode", i), 32'(mode), 32'(exp_mode[i]));
      ack = 1'b1;
      ticks(1);
      ack = 1'b0;
    end
    half = 6;
    ticks(40);
    enable = 1'b1;
    ticks(62);
    enable = 1'b0;
    ticks(1);
    check("abort_valid", 32'(valid), 0);
    check("abort_count", 32'(count), 4);
    check("abort_mode", 32'(mode), 1);
    ticks(100);
    check("abort_nopub", 32'(valid), 0);
    enable = 1'b1;
    ticks(122);
    check("reen_pre_valid", 32'(valid), 0);
    ticks(1);
    check("reen_valid", 32'(valid), 1);
    check("reen_count", 32'(count), 10);
    check("reen_mode", 32'(mode), 2);
    ticks(50);
    #3 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_mode", 32'(mode), 0);
    check("arst_valid", 32'(valid), 0);
    check("arst_ovr", 32'(ovr), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    ticks(122);
    check("post_rst_pre_valid", 32'(valid), 0);
    ticks(1);
    check("post_rst_valid", 32'(valid), 1);
    check("post_rst_mode", 32'(mode), 2);
    enable = 1'b0;
    ticks(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
